debounce_toggle_gen: RTL and testbench

- Conditions a raw, bouncing push-button into a clean single-cycle toggle-enable pulse `T` that drives the T flip-flop stage directly downstream.
- Synchronises the asynchronous input and filters bounce with a stability counter.
- Also exports the debounced level for LEDs and status.
- One per button, on the board clock domain.

---
 rtl/deb_defs.sv | 24 ++
 rtl/sync_ff_chain.sv | 37 +++
 rtl/debounce_toggle_gen.sv | 143 ++++++++++++++
 tb/tb_debounce_toggle_gen.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/deb_defs.sv
// ============================================================================
//  Module      : deb_defs (package)
//  Description : Shared definitions for button debounce blocks: 2-bit FSM
//                state encodings and the default synchroniser depth and
//                stability window used by every button instance on the board.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package deb_defs;

    // Debounce FSM state encodings (2-bit, legacy-compatible values)
    localparam logic [1:0] ST_IDLE_LO = 2'd0;
    localparam logic [1:0] ST_WAIT_HI = 2'd1;
    localparam logic [1:0] ST_IDLE_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    // Board-wide defaults for button conditioning
    localparam int DEB_SYNC_STAGES_DEF   = 2;
    localparam int DEB_STABLE_CYCLES_DEF = 50000;

endpackage : deb_defs

`default_nettype wire

// File: rtl/sync_ff_chain.sv
// ============================================================================
//  Module      : sync_ff_chain
//  Description : Multi-flop synchroniser for a single asynchronous input.
//                q is d delayed by exactly STAGES rising edges of CLK.
//  Ports       : CLK  - clock
//                rst  - synchronous active-high reset (clears every stage)
//                d    - asynchronous input
//                q    - synchronised output
//  Parameters  : STAGES - number of flops, 2..4
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge CLK) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule : sync_ff_chain

`default_nettype wire

// File: rtl/debounce_toggle_gen.sv
// ============================================================================
//  Module      : debounce_toggle_gen
//  Description : Push-button conditioner. Synchronises a raw bouncing button,
//                qualifies every level change with a stability counter and
//                emits a one-cycle toggle-enable pulse T on each accepted
//                press, plus the debounced level.
//  Ports       : CLK       - board clock
//                rst       - synchronous active-high reset
//                btn_in    - raw asynchronous button level (active-high)
//                T         - one-cycle pulse per accepted press (registered)
//                btn_level - debounced button level (registered)
//                busy      - high while a level change is being qualified
//  Parameters  : SYNC_STAGES   - synchroniser depth, 2..4
//                STABLE_CYCLES - qualification window, >= 2
//  Build macro : DEB_RELEASE_PULSE_EN - when defined, an accepted release
//                also pulses T (hold-to-toggle downstream).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_toggle_gen
    import deb_defs::*;
#(
    parameter int SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEF
) (
    input  logic CLK,
    input  logic rst,
    input  logic btn_in,
    output logic T,
    output logic btn_level,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef DEB_RELEASE_PULSE_EN
    localparam logic REL_PULSE = 1'b1;
`else
    localparam logic REL_PULSE = 1'b0;
`endif

    logic             sync_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             t_q,     t_d;
    logic             busy_q,  busy_d;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK (CLK),
        .rst (rst),
        .d   (btn_in),
        .q   (sync_q)
    );

    // The IDLE state already counts the first differing sample (counter <= 1),
    // so acceptance happens on the STABLE_CYCLES-th consecutive differing sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        t_d     = 1'b0;
        case (state_q)
            ST_IDLE_LO: begin
                if (sync_q) begin
                    state_d = ST_WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_WAIT_HI: begin
                if (!sync_q) begin
                    state_d = ST_IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE_HI;
                    level_d = 1'b1;
                    t_d     = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE_HI: begin
                if (!sync_q) begin
                    state_d = ST_WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LO: begin
                if (sync_q) begin
                    state_d = ST_IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE_LO;
                    level_d = 1'b0;
                    t_d     = REL_PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
        // busy is registered alongside the state, so derive it from state_d
        busy_d = (state_d == ST_WAIT_HI) || (state_d == ST_WAIT_LO);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= ST_IDLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            t_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
        end
    end

    assign T         = t_q;
    assign btn_level = level_q;
    assign busy      = busy_q;

endmodule : debounce_toggle_gen

`default_nettype wire

// File: tb/tb_debounce_toggle_gen.sv
// ============================================================================
//  Module      : tb_debounce_toggle_gen
//  Description : Self-checking bench for debounce_toggle_gen with
//                SYNC_STAGES=2, STABLE_CYCLES=4. A run-length reference model
//                is compared against the DUT every cycle; directed scenarios
//                add literal edge-accurate expectations; a random phase
//                follows.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_toggle_gen;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;

`ifdef DEB_RELEASE_PULSE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic CLK;
    logic rst;
    logic btn_in;
    logic T;
    logic btn_level;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    debounce_toggle_gen #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .btn_in    (btn_in),
        .T         (T),
        .btn_level (btn_level),
        .busy      (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the FSM sees btn_in from SYNC edges earlier; a new
    // level is committed once STABLE consecutive samples differ from the
    // committed level. A matching sample restarts the run.
    // ------------------------------------------------------------------
    bit hist [SYNC];
    bit m_level = 1'b0;
    bit m_t     = 1'b0;
    int m_run   = 0;
    bit m_valid = 1'b0;

    always @(posedge CLK) begin
        bit s;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
            m_level = 1'b0;
            m_t     = 1'b0;
            m_run   = 0;
        end else begin
            s = hist[0];
            for (int i = 0; i < SYNC - 1; i++) hist[i] = hist[i+1];
            hist[SYNC-1] = btn_in;
            m_t = 1'b0;
            if (s != m_level) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_level = ~m_level;
                    m_t     = m_level ? 1'b1 : REL;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("model_T",         int'(T),         int'(m_t));
            chk("model_btn_level", int'(btn_level), int'(m_level));
            chk("model_busy",      int'(busy),      int'(m_run != 0));
        end
    end

    // Downstream toggle flop fed by T
    logic tff;
    always @(posedge CLK) begin
        if (rst) tff <= 1'b0;
        else if (T) tff <= ~tff;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int tcount;
        bit exp_tff [3];
        rst    = 1'b1;
        btn_in = 1'b1;

        // 1. Reset held with button high, then fresh press after release
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_T",     int'(T),         0);
            chk("rst_level", int'(btn_level), 0);
            chk("rst_busy",  int'(busy),      0);
        end
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("post_rst_T",     int'(T),         int'(e == 6));
            chk("post_rst_level", int'(btn_level), int'(e >= 6));
            chk("post_rst_busy",  int'(busy),      int'(e >= 3 && e <= 5));
        end
        settle(5);

        // 4. Release from pressed state
        btn_in = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("rel_level", int'(btn_level), int'(e < 6));
            chk("rel_T",     int'(T),         int'(e == 6 && REL));
        end
        settle(8);

        // 2. Clean press, held 20 cycles
        btn_in = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            chk("press_T",     int'(T),         int'(e == 6));
            chk("press_level", int'(btn_level), int'(e >= 6));
            chk("press_busy",  int'(busy),      int'(e >= 3 && e <= 5));
        end
        btn_in = 1'b0;
        settle(12);

        // 3. Bounce rejection: 1,1,1,0 x5 then steady high
        tcount = 0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                btn_in = (k != 3);
                step();
                tcount += int'(T);
            end
        end
        chk("bounce_no_T", tcount, 0);
        btn_in = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("bounce_final_T", int'(T), int'(e == 6));
        end
        btn_in = 1'b0;
        settle(12);

        // 5. Reset during qualification, button still held afterwards
        btn_in = 1'b1;
        settle(3);
        rst = 1'b1;
        step();
        chk("midrst_T",     int'(T),         0);
        chk("midrst_level", int'(btn_level), 0);
        chk("midrst_busy",  int'(busy),      0);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("midrst_fresh_T", int'(T), int'(e == 6));
        end
        btn_in = 1'b0;
        settle(12);

        // 6. Three separated presses driving a toggle flop
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_tff[0] = 1'b1;
        exp_tff[1] = REL ? 1'b1 : 1'b0;
        exp_tff[2] = 1'b1;
        for (int p = 0; p < 3; p++) begin
            btn_in = 1'b1;
            settle(10);
            chk("tff_after_press", int'(tff), int'(exp_tff[p]));
            btn_in = 1'b0;
            settle(10);
        end

        // Random phase: bursts of random length, occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                settle(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end
            btn_in = 1'($urandom_range(0, 1));
            settle(int'($urandom_range(1, 9)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_debounce_toggle_gen

`default_nettype wire
